// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared types and constants for the console I/O blocks
//
// Purpose: state type, SC bit positions and serial clock divider defaults
// used by serial_port and its helpers. No ports.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } serial_state_t;

  localparam int SC_START = 7;
  localparam int SC_FAST  = 1;
  localparam int SC_SRC   = 0;

  // System clocks per serial-clock half period.
  localparam int SERIAL_HALF_SLOW = 256;
  localparam int SERIAL_HALF_FAST = 8;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rise/fall pulse outputs
//
// Purpose: bring an asynchronous pin into the clk domain and flag its edges.
// Ports:
//   clk       in   system clock
//   n_reset   in   asynchronous active-low reset
//   async_in  in   asynchronous input pin
//   level     out  synchronized level (two flops of latency)
//   rise      out  one-cycle pulse, synchronized level went 0 -> 1
//   fall      out  one-cycle pulse, synchronized level went 1 -> 0
module sync_edge #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // pipe[0], pipe[1]: synchronizer; pipe[2]: previous synchronized level.
  logic [2:0] pipe;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pipe <= {3{RESET_LEVEL}};
    end else begin
      pipe <= {pipe[1:0], async_in};
    end
  end

  assign level = pipe[1];
  assign rise  = pipe[1] & ~pipe[2];
  assign fall  = ~pipe[1] & pipe[2];

endmodule

// File: rtl/serial_port.sv
// rtl/serial_port.sv - link-port responder holding SB/SC and shifting 8 bits
//
// Purpose: SB (shift register) and SC (start/fast/src) registers, serial
// clock generation or external clock following, one-cycle irq at the end.
// Ports:
//   clk, n_reset         system clock, asynchronous active-low reset
//   target, reg_select   register access strobe, 0 = SB / 1 = SC
//   write, wdata         write enable and data
//   rdata                combinational read data of the selected register
//   cgb_mode             enables the SC fast bit
//   sclk_in, sin         external serial clock and data (asynchronous)
//   sclk_out, sclk_oe    internal serial clock (idle high) and its enable
//   sout                 serial data out (idle high)
//   irq                  one-cycle transfer-complete request
module serial_port
  import console_pkg::*;
#(
  parameter int HALF_SLOW = SERIAL_HALF_SLOW,
  parameter int HALF_FAST = SERIAL_HALF_FAST
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       target,
  input  logic       reg_select,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       cgb_mode,
  input  logic       sclk_in,
  input  logic       sin,
  output logic       sclk_out,
  output logic       sclk_oe,
  output logic       sout,
  output logic       irq
);

  localparam logic [8:0] SLOW_LAST = 9'(HALF_SLOW - 1);
  localparam logic [8:0] FAST_LAST = 9'(HALF_FAST - 1);

  serial_state_t state;
  logic [7:0]    sb;
  logic          sc_start, sc_fast, sc_src;
  logic [3:0]    bit_cnt;
  logic [8:0]    div;
  // Source and speed actually in use; SC changes are picked up at reloads.
  logic          cur_src, cur_fast;
  logic          fast_eff;

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic sin_sync, sin_rise_unused, sin_fall_unused;
  logic term, reload, do_rise, do_fall, done;

  sync_edge u_sclk_sync (
    .clk      (clk),
    .n_reset  (n_reset),
    .async_in (sclk_in),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge u_sin_sync (
    .clk      (clk),
    .n_reset  (n_reset),
    .async_in (sin),
    .level    (sin_sync),
    .rise     (sin_rise_unused),
    .fall     (sin_fall_unused)
  );

  assign fast_eff = sc_fast & cgb_mode;
  assign sclk_out = (state != LOW);
  assign sclk_oe  = sc_src;

  always_comb begin
    if (reg_select) begin
      rdata = cgb_mode ? {sc_start, 5'b11111, fast_eff, sc_src}
                       : {sc_start, 6'b111111, sc_src};
    end else begin
      rdata = sb;
    end
  end

  always_comb begin
    term    = 1'b0;
    reload  = 1'b0;
    do_rise = 1'b0;
    do_fall = 1'b0;
    done    = 1'b0;
    if (state != IDLE) begin
      if (cur_src) begin
        term   = (div == (cur_fast ? FAST_LAST : SLOW_LAST));
        reload = term;
        if (term) begin
          if (state == LOW) begin
            do_rise = 1'b1;
          end else if (bit_cnt == 4'd8) begin
            // The last high half period closes the transfer.
            done = 1'b1;
          end else begin
            do_fall = 1'b1;
          end
        end
      end else begin
        // The partner owns the clock: its 8th rising edge ends the transfer.
        reload  = sclk_rise | sclk_fall;
        do_rise = sclk_rise && (state == LOW);
        do_fall = sclk_fall;
        done    = do_rise && (bit_cnt == 4'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      sb       <= 8'h00;
      sc_start <= 1'b0;
      sc_fast  <= 1'b0;
      sc_src   <= 1'b0;
      bit_cnt  <= 4'd0;
      div      <= 9'd0;
      cur_src  <= 1'b0;
      cur_fast <= 1'b0;
      sout     <= 1'b1;
      irq      <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (state != IDLE && cur_src) begin
        div <= term ? 9'd0 : div + 9'd1;
      end
      if (reload) begin
        cur_src  <= sc_src;
        cur_fast <= fast_eff;
      end
      if (do_rise) begin
        sb      <= {sb[6:0], sin_sync};
        bit_cnt <= bit_cnt + 4'd1;
        state   <= HIGH;
      end
      if (do_fall) begin
        sout  <= sb[7];
        state <= LOW;
      end
      if (done) begin
        sc_start <= 1'b0;
        state    <= IDLE;
        irq      <= 1'b1;
      end
      // CPU writes come last so they win over the shifter in the same cycle.
      if (target && write) begin
        if (!reg_select) begin
          sb <= wdata;
        end else begin
          sc_start <= wdata[SC_START];
          sc_fast  <= wdata[SC_FAST] & cgb_mode;
          sc_src   <= wdata[SC_SRC];
          irq      <= 1'b0;
          if (wdata[SC_START]) begin
            // The start write acts as the first falling edge.
            state    <= LOW;
            bit_cnt  <= 4'd0;
            div      <= 9'd0;
            sout     <= sb[7];
            cur_src  <= wdata[SC_SRC];
            cur_fast <= wdata[SC_FAST] & cgb_mode;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// tb/tb_serial_port.sv - self-checking bench for serial_port
module tb_serial_port;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       target, reg_select, write;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       cgb_mode, sclk_in, sin;
  logic       sclk_out, sclk_oe, sout, irq;

  int checks   = 0;
  int failures = 0;

  serial_port dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .target     (target),
    .reg_select (reg_select),
    .write      (write),
    .wdata      (wdata),
    .rdata      (rdata),
    .cgb_mode   (cgb_mode),
    .sclk_in    (sclk_in),
    .sin        (sin),
    .sclk_out   (sclk_out),
    .sclk_oe    (sclk_oe),
    .sout       (sout),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] data);
    reg_select = sel;
    wdata      = data;
    target     = 1'b1;
    write      = 1'b1;
    step();
    target     = 1'b0;
    write      = 1'b0;
    reg_select = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic sel, input logic [7:0] exp);
    reg_select = sel;
    #1;
    check(tag, rdata, exp);
    reg_select = 1'b0;
  endtask

  // Internal-clock transfer: tx goes out MSB first, rx comes in MSB first,
  // the transfer takes 16 half periods and irq follows the last one.
  task automatic run_internal(input logic [7:0] tx, input logic [7:0] rx, input logic fast);
    int half, total, irq_n, irq_at, k, ph;
    half   = fast ? 8 : 256;
    total  = 16 * half;
    irq_n  = 0;
    irq_at = -1;
    sin    = rx[7];
    write_reg(1'b0, tx);
    write_reg(1'b1, fast ? 8'h83 : 8'h81);
    for (int n = 0; n < total + 4; n++) begin
      if (irq === 1'b1) begin
        irq_n++;
        irq_at = n;
      end
      k  = n / (2 * half);
      ph = n % (2 * half);
      if (k < 8) begin
        if (ph == 2) sin = rx[7 - k];
        if (ph == half / 2) begin
          check("int_sout", sout, tx[7 - k]);
          check("int_sclk_low", sclk_out, 1'b0);
          if (k == 0) read_check("int_sc_busy", 1'b1, 8'hFF);
        end
        if (ph == half + half / 2) check("int_sclk_high", sclk_out, 1'b1);
      end
      step();
    end
    check("int_irq_count", irq_n, 1);
    check("int_irq_cycle", irq_at, total);
    check("int_sclk_idle", sclk_out, 1'b1);
    check("int_sclk_oe", sclk_oe, 1'b1);
    read_check("int_sb", 1'b0, rx);
    read_check("int_sc_done", 1'b1, 8'h7F);
  endtask

  initial begin
    logic [7:0] tx, rx;
    int irq_n;

    n_reset    = 1'b0;
    target     = 1'b0;
    reg_select = 1'b0;
    write      = 1'b0;
    wdata      = 8'h00;
    cgb_mode   = 1'b0;
    sclk_in    = 1'b1;
    sin        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    step();

    // Reset state.
    read_check("rst_sb", 1'b0, 8'h00);
    read_check("rst_sc", 1'b1, 8'h7E);
    check("rst_sout", sout, 1'b1);
    check("rst_sclk_out", sclk_out, 1'b1);
    check("rst_sclk_oe", sclk_oe, 1'b0);
    check("rst_irq", irq, 1'b0);

    // Slow internal transfer, sin held low.
    run_internal(8'hA5, 8'h00, 1'b0);

    // Fast CGB transfers: all-ones input, then random data both ways.
    cgb_mode = 1'b1;
    run_internal(8'($urandom), 8'hFF, 1'b1);
    tx = 8'($urandom);
    rx = 8'($urandom);
    run_internal(tx, rx, 1'b1);
    tx = 8'($urandom);
    rx = 8'($urandom);
    run_internal(tx, rx, 1'b1);
    cgb_mode = 1'b0;

    // External clock: 8 pulses of period 40, data 0x3C.
    tx    = 8'($urandom);
    rx    = 8'h3C;
    irq_n = 0;
    write_reg(1'b0, tx);
    write_reg(1'b1, 8'h80);
    for (int k = 0; k < 8; k++) begin
      sclk_in = 1'b0;
      sin     = rx[7 - k];
      for (int c = 0; c < 20; c++) begin
        step();
        if (irq === 1'b1) irq_n++;
        if (c == 10) begin
          check("ext_sout", sout, tx[7 - k]);
          check("ext_sclk_oe", sclk_oe, 1'b0);
        end
      end
      sclk_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
        step();
        if (irq === 1'b1) irq_n++;
        if (c == 10) check("ext_sclk_oe", sclk_oe, 1'b0);
      end
    end
    repeat (10) begin
      step();
      if (irq === 1'b1) irq_n++;
    end
    check("ext_irq_count", irq_n, 1);
    read_check("ext_sb", 1'b0, 8'h3C);
    read_check("ext_sc", 1'b1, 8'h7E);

    // Abort after three bits with sin high: no irq, partial SB kept.
    tx    = 8'($urandom);
    sin   = 1'b1;
    irq_n = 0;
    write_reg(1'b0, tx);
    write_reg(1'b1, 8'h81);
    repeat (1400) begin
      step();
      if (irq === 1'b1) irq_n++;
    end
    write_reg(1'b1, 8'h01);
    check("abort_sclk_out", sclk_out, 1'b1);
    read_check("abort_sc", 1'b1, 8'h7F);
    repeat (4500) begin
      step();
      if (irq === 1'b1) irq_n++;
    end
    check("abort_irq", irq_n, 0);
    check("abort_sclk_idle", sclk_out, 1'b1);
    read_check("abort_sb", 1'b0, {tx[4:0], 3'b111});

    // Reset in the middle of a transfer.
    irq_n = 0;
    write_reg(1'b0, 8'h00);
    write_reg(1'b1, 8'h81);
    repeat (100) step();
    check("pre_rst_sclk_low", sclk_out, 1'b0);
    check("pre_rst_sout", sout, 1'b0);
    n_reset = 1'b0;
    #2;
    check("mid_rst_sout", sout, 1'b1);
    check("mid_rst_sclk_out", sclk_out, 1'b1);
    check("mid_rst_sclk_oe", sclk_oe, 1'b0);
    check("mid_rst_irq", irq, 1'b0);
    read_check("mid_rst_sb", 1'b0, 8'h00);
    read_check("mid_rst_sc", 1'b1, 8'h7E);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (5000) begin
      step();
      if (irq === 1'b1) irq_n++;
    end
    check("post_rst_irq", irq_n, 0);
    check("post_rst_sclk_out", sclk_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
